pe_tile_param: RTL
==================

// Module: pe_tile_param
// PURPOSE
// - Parametrised successor of the single-bit PE tile: WIDTH-bit datapath, NUM_TRACKS tracks per side, all four sides driven.
// - Two connect boxes pick PE operands from side-0/side-1 tracks. A registered ALU/accumulator PE drives the switch box.
// - Per-track switch boxes on all four sides route neighbour tracks or the PE result to the outputs.
// - Configured over the shared config_addr/config_data bus; tiles in the array are distinguished by tile_id.
// PARAMETERS
// - WIDTH       16  data bits per track, PE operand and PE result
// - NUM_TRACKS  4   tracks per side; 1..16; CB select field width CBW = clog2(2*NUM_TRACKS)
// PORTS
// - clk           in   1                     clock, rising edge
// - reset         in   1                     synchronous, active-high
// - config_addr   in   32                    [15:0] tile id match, [31:16] feature id
// - config_data   in   32                    configuration payload
// - config_we     in   1                     write strobe; config is written only when this is high
// - tile_id       in   16                    static tile id
// - in_wires      in   4*NUM_TRACKS*WIDTH    side-major: side s, track t at [(s*NUM_TRACKS+t)*WIDTH +: WIDTH]
// - out_wires     out  4*NUM_TRACKS*WIDTH    same packing as in_wires
// - pe_out        out  WIDTH                 registered PE result, exported for debug/observation
// BEHAVIOUR
// - Config write: fires when config_we=1 and addr[15:0]==tile_id. Feature field selects the target:
//   - 4   -> PE op = data[2:0]
//   - 5   -> cb1 select = data[CBW-1:0]
//   - 6   -> cb0 select = data[CBW-1:0]
//   - 7+s (s=0..3) -> side-s switch-box selects: 2 bits per track, track t at data[2t+1:2t]
//   - any other feature id -> write ignored
// - All config registers take effect on the cycle after the write edge.
// - Reset: all config registers, the accumulator and pe_out go to 0. Therefore:
//   - op = ADD, cb selects = track 0, sb selects = 0.
//   - out_wires reset to 0 only when the SB register option is compiled in; otherwise they follow the inputs combinationally.
//   - reset has priority over a simultaneous config write or accumulate.
// - Connect box (combinational):
//   - sel < NUM_TRACKS: in_wires side k, track sel (k=0 for cb0, k=1 for cb1).
//   - sel in NUM_TRACKS..2*NUM_TRACKS-1: out_wires of the same side, track sel-NUM_TRACKS.
//   - sel >= 2*NUM_TRACKS: 0.
//   - cb0 result = op_0; cb1 result = op_1.
// - PE: 1-cycle latency; pe_out <= f(op_0, op_1) every cycle. All arithmetic is mod 2^WIDTH, no saturation, no flags.
//   - op codes: 0 ADD, 1 SUB (op_0-op_1), 2 AND, 3 OR, 4 XOR, 5 PASS op_0, 6 ACC, 7 -> constant 0.
//   - ACC: acc <= acc + op_0 each cycle, wraps; pe_out mirrors acc.
//   - Any write to feature 4 clears acc to 0, including a write of the same op.
//   - Leaving ACC does not clear acc; re-entering ACC clears it via that rule.
// - Switch box, output side s, track t; 2-bit select:
//   - 0..2 -> in_wires side (s+1+sel)%4, same track t
//   - 3    -> pe_out
// - No combinational loop through the tile: the only path out->cb->PE is broken by the PE register.
//   - CB sel >= NUM_TRACKS reading out_wires is legal for that reason.
// CONFIGURATION
// - PE_TILE_SB_REG_EN defined:
//   - every out_wires track is registered; +1 cycle in->out latency; reset value 0.
//   - a PE result appears on out_wires 2 cycles after its operands.
// - PE_TILE_SB_REG_EN undefined:
//   - out_wires are combinational from in_wires/pe_out, 0-cycle latency.
// TESTING
// (WIDTH=16, NUM_TRACKS=4, tile_id=0x0003)
// - Reset with no config writes -> pe_out=0; the first clock after reset gives pe_out = in side0 t0 + in side1 t0.
// - cb0=2, cb1=1, op=1 with side0 t2=0x0005 and side1 t1=0x0007 -> pe_out=0xFFFE one cycle later.
// - op=6 with op_0=0x8000 held for 3 cycles -> pe_out sequence 0x8000, 0x0000, 0x8000.
//   - then rewrite op=6 -> pe_out 0 at the next edge.
// - Write to feature 7 with addr[15:0]=0x0004 (wrong tile), or with config_we=0 -> no config change.
// - Side-2 selects = 0xFF (all tracks take pe_out), op=5 -> every side-2 output track = op_0.
//   - latency: 1 cycle without the macro, 2 cycles with PE_TILE_SB_REG_EN.
// - reset asserted in the same cycle as a config write and during ACC -> config stays 0, acc=0, pe_out=0.

Source files
------------

// File: rtl/pe_tile_param.sv
// ---------------------------------------------------------------------------
// pe_tile_param
//
// Parametrised routing/compute tile. Each of the four sides carries
// NUM_TRACKS tracks of WIDTH bits.
// - Two connect boxes pick the PE operands. cb0 reads side 0 and cb1 reads
//   side 1. Each can pick an input track or an output track of its side.
// - A registered ALU/accumulator PE computes pe_out from the two operands.
// - Per-track switch boxes on all four sides drive out_wires. Each track
//   takes a neighbour side's input track or the PE result.
// - Configuration arrives over a shared address/data bus. A write applies
//   only when config_addr[15:0] matches tile_id.
//
// Optional feature: define PE_TILE_SB_REG_EN to register every out_wires
// track. This adds one cycle of latency, and the registers reset to 0.
// Without the macro, out_wires are combinational.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; clears all state
//   config_addr  in   [15:0] tile id match, [31:16] feature id
//   config_data  in   configuration payload
//   config_we    in   configuration write strobe
//   tile_id      in   static id of this tile
//   in_wires     in   side s, track t at [(s*NUM_TRACKS+t)*WIDTH +: WIDTH]
//   out_wires    out  same packing as in_wires
//   pe_out       out  registered PE result
// ---------------------------------------------------------------------------
module pe_tile_param #(
    parameter int WIDTH      = 16,
    parameter int NUM_TRACKS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      config_addr,
    input  logic [31:0]                      config_data,
    input  logic                             config_we,
    input  logic [15:0]                      tile_id,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]    in_wires,
    output logic [4*NUM_TRACKS*WIDTH-1:0]    out_wires,
    output logic [WIDTH-1:0]                 pe_out
);

    localparam int CBW = $clog2(2 * NUM_TRACKS);
    localparam int NCB = 1 << CBW;
    localparam int SBW = 2 * NUM_TRACKS;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;
    localparam logic [2:0] OP_ACC  = 3'd6;
    localparam logic [2:0] OP_ZERO = 3'd7;

    // Configuration and PE state
    logic [2:0]            op_q,  op_d;
    logic [CBW-1:0]        cb0_q, cb0_d;
    logic [CBW-1:0]        cb1_q, cb1_d;
    logic [3:0][SBW-1:0]   sb_q,  sb_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      pe_q,  pe_d;

    logic                  cfg_hit_s;
    logic [15:0]           feature_s;
    logic                  op_wr_s;
    logic [WIDTH-1:0]      op0_s, op1_s, res_s;
    logic [4*NUM_TRACKS*WIDTH-1:0] sb_s;
    logic [WIDTH-1:0]      cb0_cand_s [NCB];
    logic [WIDTH-1:0]      cb1_cand_s [NCB];

    assign cfg_hit_s = config_we && (config_addr[15:0] == tile_id);
    assign feature_s = config_addr[31:16];
    assign pe_out    = pe_q;

    // Configuration decode: next-state of the op, connect box and switch box registers
    always_comb begin
        op_d    = op_q;
        cb0_d   = cb0_q;
        cb1_d   = cb1_q;
        sb_d    = sb_q;
        op_wr_s = 1'b0;
        if (cfg_hit_s) begin
            case (feature_s)
                16'd4: begin
                    op_d    = config_data[2:0];
                    op_wr_s = 1'b1;
                end
                16'd5:   cb1_d   = config_data[CBW-1:0];
                16'd6:   cb0_d   = config_data[CBW-1:0];
                16'd7:   sb_d[0] = config_data[SBW-1:0];
                16'd8:   sb_d[1] = config_data[SBW-1:0];
                16'd9:   sb_d[2] = config_data[SBW-1:0];
                16'd10:  sb_d[3] = config_data[SBW-1:0];
                default: op_wr_s = 1'b0;
            endcase
        end else begin
            op_wr_s = 1'b0;
        end
    end

    // Connect box candidates. Select codes past the output tracks read as zero.
    // Reading out_wires here is loop-free because the PE register breaks the path.
    for (genvar i = 0; i < NCB; i++) begin : g_cb
        if (i < NUM_TRACKS) begin : g_in
            assign cb0_cand_s[i] = in_wires[i*WIDTH +: WIDTH];
            assign cb1_cand_s[i] = in_wires[(NUM_TRACKS+i)*WIDTH +: WIDTH];
        end else if (i < 2 * NUM_TRACKS) begin : g_out
            assign cb0_cand_s[i] = out_wires[(i-NUM_TRACKS)*WIDTH +: WIDTH];
            assign cb1_cand_s[i] = out_wires[i*WIDTH +: WIDTH];
        end else begin : g_zero
            assign cb0_cand_s[i] = '0;
            assign cb1_cand_s[i] = '0;
        end
    end

    assign op0_s = cb0_cand_s[cb0_q];
    assign op1_s = cb1_cand_s[cb1_q];

    // ALU: all arithmetic wraps mod 2^WIDTH
    always_comb begin
        res_s = '0;
        case (op_q)
            OP_ADD:  res_s = op0_s + op1_s;
            OP_SUB:  res_s = op0_s - op1_s;
            OP_AND:  res_s = op0_s & op1_s;
            OP_OR:   res_s = op0_s | op1_s;
            OP_XOR:  res_s = op0_s ^ op1_s;
            OP_PASS: res_s = op0_s;
            OP_ACC:  res_s = acc_q + op0_s;
            OP_ZERO: res_s = '0;
            default: res_s = '0;
        endcase
    end

    // Accumulator next state. An op write clears it, and in ACC mode pe_out tracks the accumulator.
    always_comb begin
        acc_d = acc_q;
        pe_d  = res_s;
        if (op_wr_s) begin
            acc_d = '0;
        end else if (op_q == OP_ACC) begin
            acc_d = res_s;
        end else begin
            acc_d = acc_q;
        end
        if (op_q == OP_ACC) begin
            pe_d = acc_d;
        end else begin
            pe_d = res_s;
        end
    end

    // Switch box: 0..2 pick the next sides round the tile, 3 picks the PE result
    always_comb begin
        sb_s = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                case (sb_q[s][2*t +: 2])
                    2'd0:    sb_s[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                                 in_wires[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    2'd1:    sb_s[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                                 in_wires[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    2'd2:    sb_s[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                                 in_wires[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    2'd3:    sb_s[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = pe_q;
                    default: sb_s[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = '0;
                endcase
            end
        end
    end

    // State registers; reset wins over any config write or accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= 3'd0;
            cb0_q <= '0;
            cb1_q <= '0;
            sb_q  <= '0;
            acc_q <= '0;
            pe_q  <= '0;
        end else begin
            op_q  <= op_d;
            cb0_q <= cb0_d;
            cb1_q <= cb1_d;
            sb_q  <= sb_d;
            acc_q <= acc_d;
            pe_q  <= pe_d;
        end
    end

`ifdef PE_TILE_SB_REG_EN
    logic [4*NUM_TRACKS*WIDTH-1:0] out_q;

    // Registered switch box outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= sb_s;
        end
    end

    assign out_wires = out_q;
`else
    assign out_wires = sb_s;
`endif

endmodule
